// File: rtl/spi_instr_prefetch.sv
// Instruction prefetch: fetches opcode/operand byte pairs over the SPI byte reader
// into a small FIFO presented to the execute stage via valid/ready.
`timescale 1ns/1ps
module spi_instr_prefetch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       rd_start,
  output logic [15:0]                rd_addr,
  input  logic                       rd_busy,
  input  logic                       rd_done,
  input  logic [7:0]                 rd_data,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [3:0]                 instr_opcode,
  output logic [7:0]                 instr_operand,
  output logic [PC_W-1:0]            instr_pc,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = PC_W + 12;

  typedef enum logic [2:0] {IDLE, REQ_OP, WAIT_OP, REQ_ARG, WAIT_ARG, DRAIN} state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] fetch_pc;
  logic [3:0]      op_pend;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop, op_latch;

  assign pop = (count != '0) && instr_ready && !redirect;

  // Next state and request strobes; redirect overrides everything
  always_comb begin
    state_nx = state;
    rd_start = 1'b0;
    push     = 1'b0;
    op_latch = 1'b0;
    case (state)
      IDLE:     if (!redirect && count < CW'(DEPTH)) state_nx = REQ_OP;
      REQ_OP: begin
        if (redirect) state_nx = IDLE;
        else if (!rd_busy) begin
          rd_start = 1'b1;
          state_nx = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (redirect) state_nx = rd_done ? IDLE : DRAIN;
        else if (rd_done) begin
          op_latch = 1'b1;
          state_nx = REQ_ARG;
        end
      end
      REQ_ARG: begin
        if (redirect) state_nx = IDLE;
        else if (!rd_busy) begin
          rd_start = 1'b1;
          state_nx = WAIT_ARG;
        end
      end
      WAIT_ARG: begin
        if (redirect) state_nx = rd_done ? IDLE : DRAIN;
        else if (rd_done) begin
          push     = 1'b1;
          state_nx = IDLE;
        end
      end
      DRAIN:    if (rd_done) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Fetch PC, pending opcode and request address (loaded on entry to a request state)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= '0;
      op_pend  <= '0;
      rd_addr  <= '0;
    end else begin
      if (redirect)  fetch_pc <= redirect_pc;
      else if (push) fetch_pc <= fetch_pc + PC_W'(1);
      if (op_latch) op_pend <= rd_data[3:0];
      if (state_nx == REQ_OP && state != REQ_OP)   rd_addr <= 16'({fetch_pc, 1'b0});
      if (state_nx == REQ_ARG && state != REQ_ARG) rd_addr <= 16'({fetch_pc, 1'b1});
    end
  end

  // Instruction FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {fetch_pc, op_pend, rd_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign {instr_pc, instr_opcode, instr_operand} = mem[rd_ptr];
  assign instr_valid = (count != '0);
  assign fifo_count  = count;

endmodule

// File: tb/tb_spi_instr_prefetch.sv
// Directed bench for spi_instr_prefetch with a two-cycle-latency byte reader model.
`timescale 1ns/1ps
module tb_spi_instr_prefetch;

  logic        clk, reset;
  logic        rd_start, rd_busy, rd_done;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        instr_valid, instr_ready;
  logic [3:0]  instr_opcode;
  logic [7:0]  instr_operand;
  logic [11:0] instr_pc;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic [2:0]  fifo_count;

  spi_instr_prefetch #(.DEPTH(4), .PC_W(12)) dut (
    .clk(clk), .reset(reset),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_busy(rd_busy),
    .rd_done(rd_done), .rd_data(rd_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap = 0;
  logic force_busy = 1'b0;
  logic [15:0] start_log [$];
  logic [15:0] last_addr = 16'h0;

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] addr;
    logic [3:0]  op;
    logic [7:0]  arg;
  } vec_t;
  vec_t vecs [4];

  function automatic logic [7:0] byte_at(input logic [15:0] a);
    if (a == 16'h0000) return 8'hF3;
    if (a == 16'h0001) return 8'hA5;
    return a[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [15:0] log_at(input int i);
    if (start_log.size() > i) return start_log[i];
    return 16'hDEAD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 50; i++) begin
      step();
      if (rd_done) return;
    end
    chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 60; i++) begin
      if (instr_valid) return;
      step();
    end
    chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic do_redirect(input logic [11:0] pc);
    redirect = 1'b1;
    redirect_pc = pc;
    step();
    redirect = 1'b0;
  endtask

  task automatic pop_one();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  // Byte reader: start seen at negedge+4, busy next cycle, done two cycles after start
  initial begin
    int cnt;
    logic pending;
    logic [15:0] paddr;
    pending = 1'b0; cnt = 0; paddr = '0;
    rd_busy = 1'b0; rd_done = 1'b0; rd_data = 8'hEE;
    forever begin
      @(negedge clk);
      #1;
      rd_done = 1'b0;
      rd_data = 8'hEE;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          rd_done = 1'b1;
          rd_data = byte_at(paddr);
          pending = 1'b0;
        end
      end
      rd_busy = force_busy || pending;
      #3;
      if (rd_start) begin
        if (pending || rd_busy) overlap++;
        start_log.push_back(rd_addr);
        last_addr = rd_addr;
        paddr = rd_addr;
        pending = 1'b1;
        cnt = 2;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base, n;
    vecs[0] = '{12'h005, 16'h000A, 4'h6, 8'h37};
    vecs[1] = '{12'h7FF, 16'h0FFE, 4'h2, 8'hC3};
    vecs[2] = '{12'h800, 16'h1000, 4'hC, 8'h3D};
    vecs[3] = '{12'hABC, 16'h1578, 4'h4, 8'h45};

    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    chk("rst_start", 32'(rd_start), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_head", {8'h0, instr_pc, instr_opcode, instr_operand}, 32'd0);
    reset = 1'b0;

    // First instruction: valid one cycle after the operand byte returns
    wait_done("op0");
    wait_done("arg0");
    chk("t1_valid_at_done", 32'(instr_valid), 32'd0);
    step();
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_opcode", 32'(instr_opcode), 32'h3);
    chk("t1_operand", 32'(instr_operand), 32'hA5);
    chk("t1_pc", 32'(instr_pc), 32'h0);
    chk("t1_addr0", 32'(log_at(0)), 32'h0000);
    chk("t1_addr1", 32'(log_at(1)), 32'h0001);
    for (int i = 0; i < 10 && start_log.size() < 3; i++) step();
    chk("t1_addr2", 32'(log_at(2)), 32'h0002);

    // Fill to full, then one pop restarts fetch at PC 4
    repeat (60) step();
    chk("t2_count", 32'(fifo_count), 32'd4);
    chk("t2_nstarts", 32'(start_log.size()), 32'd8);
    chk("t2_addr7", 32'(log_at(7)), 32'h0007);
    n = start_log.size();
    repeat (10) step();
    chk("t2_no_start_full", 32'(start_log.size()), 32'(n));
    pop_one();
    chk("t2_head_pc", 32'(instr_pc), 32'h1);
    chk("t2_head_op", 32'(instr_opcode), 32'hE);
    chk("t2_head_arg", 32'(instr_operand), 32'h3F);
    step();
    chk("t2_restart", 32'(rd_start), 32'd1);
    chk("t2_restart_addr", 32'(rd_addr), 32'h0008);

    // Redirect while the opcode read is in flight
    step();
    base = start_log.size();
    do_redirect(12'h010);
    chk("t3_valid", 32'(instr_valid), 32'd0);
    chk("t3_count", 32'(fifo_count), 32'd0);
    chk("t3_drain_done", 32'(rd_done), 32'd1);
    chk("t3_drain_nostart", 32'(rd_start), 32'd0);
    wait_valid("t3");
    chk("t3_addr_op", 32'(log_at(base)), 32'h0020);
    chk("t3_addr_arg", 32'(log_at(base + 1)), 32'h0021);
    chk("t3_pc", 32'(instr_pc), 32'h010);
    chk("t3_op", 32'(instr_opcode), 32'hC);
    chk("t3_arg", 32'(instr_operand), 32'h1D);

    // Table: redirect targets and the instruction expected at the head
    for (int v = 0; v < 4; v++) begin
      base = start_log.size();
      do_redirect(vecs[v].pc);
      chk("tv_flush", 32'(instr_valid), 32'd0);
      wait_valid("tv");
      chk("tv_addr_op", 32'(log_at(base)), 32'(vecs[v].addr));
      chk("tv_addr_arg", 32'(log_at(base + 1)), 32'(vecs[v].addr | 16'h1));
      chk("tv_pc", 32'(instr_pc), 32'(vecs[v].pc));
      chk("tv_op", 32'(instr_opcode), 32'(vecs[v].op));
      chk("tv_arg", 32'(instr_operand), 32'(vecs[v].arg));
    end

    // PC wrap 0xFFF -> 0x000
    base = start_log.size();
    do_redirect(12'hFFF);
    for (int i = 0; i < 60 && fifo_count < 3'd2; i++) step();
    chk("wrap_count", 32'(fifo_count), 32'd2);
    chk("wrap_a0", 32'(log_at(base)), 32'h1FFE);
    chk("wrap_a1", 32'(log_at(base + 1)), 32'h1FFF);
    chk("wrap_a2", 32'(log_at(base + 2)), 32'h0000);
    chk("wrap_a3", 32'(log_at(base + 3)), 32'h0001);
    chk("wrap_pc0", {8'h0, instr_pc, instr_opcode, instr_operand}, 32'hFFF2C3);
    pop_one();
    chk("wrap_pc1", {8'h0, instr_pc, instr_opcode, instr_operand}, 32'h0003A5);

    // Simultaneous push and pop at count 2
    do_redirect(12'h100);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (fifo_count == 3'd2 && rd_done && last_addr[0]) begin
        n = 1;
        break;
      end
      step();
    end
    chk("pp_found", 32'(n), 32'd1);
    pop_one();
    chk("pp_count", 32'(fifo_count), 32'd2);
    chk("pp_head", {8'h0, instr_pc, instr_opcode, instr_operand}, 32'h101E3F);

    // Redirect together with a pop
    instr_ready = 1'b1;
    do_redirect(12'h200);
    instr_ready = 1'b0;
    chk("rp_count", 32'(fifo_count), 32'd0);
    chk("rp_valid", 32'(instr_valid), 32'd0);
    wait_valid("rp");
    chk("rp_head", {8'h0, instr_pc, instr_opcode, instr_operand}, 32'h200C3D);

    // Reader busy holds off the request; one pulse when busy falls
    force_busy = 1'b1;
    do_redirect(12'h020);
    base = start_log.size();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (rd_start) n++;
      step();
    end
    chk("busy_nostart", 32'(n), 32'd0);
    chk("busy_nolog", 32'(start_log.size()), 32'(base));
    force_busy = 1'b0;
    step();
    chk("busy_pulse", 32'(rd_start), 32'd1);
    chk("busy_addr", 32'(rd_addr), 32'h0040);
    step();
    chk("busy_one", 32'(start_log.size()), 32'(base + 1));
    chk("busy_pulse_end", 32'(rd_start), 32'd0);

    chk("no_overlap", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_instr_prefetch.md
Name: spi_instr_prefetch

Overview:
Instruction prefetch stage between the SPI byte reader and the execution unit. It walks a 12-bit fetch PC and issues two single-byte SPI reads per instruction: an opcode byte, then an operand byte. Completed instructions are pushed into a DEPTH-entry FIFO and presented to the execute stage through a valid/ready handshake. A redirect input flushes the buffer and restarts fetch at a new PC.

Parameters:
DEPTH, 4, number of buffered instructions (power of 2, >=2)
PC_W, 12, program counter width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
rd_start  output  1  one-cycle pulse requesting one SPI byte read at rd_addr
rd_addr  output  16  byte address of the requested read
rd_busy  input  1  byte reader is busy; no rd_start while high
rd_done  input  1  one-cycle pulse; rd_data is valid this cycle
rd_data  input  8  byte returned by the reader
instr_valid  output  1  FIFO head holds a valid instruction
instr_ready  input  1  execute stage accepts the head this cycle
instr_opcode  output  4  head opcode (rd_data[3:0] of the opcode byte)
instr_operand  output  8  head operand byte
instr_pc  output  PC_W  PC of the head instruction
redirect  input  1  flush the FIFO and restart fetch at redirect_pc
redirect_pc  input  PC_W  new fetch PC, sampled when redirect=1
fifo_count  output  $clog2(DEPTH)+1  number of buffered instructions

Behaviour:
- Reset (async, immediate): fetch_pc=0, FSM=IDLE, FIFO pointers and count=0, rd_start=0, rd_addr=0, instr_valid=0, head outputs=0.
- Address map: the opcode byte is at {3'b0, fetch_pc, 1'b0} and the operand byte is at {3'b0, fetch_pc, 1'b1}. PC_W=12 gives a 13-bit byte address, zero-extended to 16 bits.
- FSM states are IDLE, REQ_OP, WAIT_OP, REQ_ARG, WAIT_ARG, DRAIN.
  - IDLE: go to REQ_OP if fifo_count < DEPTH, else stay.
  - REQ_OP: when rd_busy=0, drive rd_start=1 for exactly one cycle with rd_addr = opcode address, then go to WAIT_OP. While rd_busy=1, stay in REQ_OP.
  - WAIT_OP: on rd_done, latch rd_data[3:0] as the pending opcode (rd_data[7:4] is ignored), then go to REQ_ARG.
  - REQ_ARG: same as REQ_OP, using the operand address, then go to WAIT_ARG.
  - WAIT_ARG: on rd_done, push {fetch_pc, opcode, rd_data}, increment fetch_pc modulo 2^PC_W (4095 wraps to 0), then go to IDLE.
  - DRAIN: wait for rd_done, discard the byte, then go to IDLE.
- Only one read is outstanding at a time. rd_start is never asserted outside REQ_OP/REQ_ARG.
- rd_addr is registered and stable from the rd_start cycle until the next request.
- A push in cycle N makes instr_valid=1 in cycle N+1 if the FIFO was empty. There is no combinational bypass.
- Pop: a pop occurs when instr_valid & instr_ready. The head advances on that edge.
- Push and pop in the same cycle: count is unchanged and both succeed.
- instr_ready while instr_valid=0 is ignored.
- Outputs are the FIFO head, read combinationally from the storage array at the read pointer. They are stable while instr_valid=1 and not popped.
- Redirect has the highest priority:
  - FIFO is cleared (count=0, pointers=0) and fetch_pc=redirect_pc on that edge. instr_valid=0 the next cycle.
  - A pop or push in the same cycle is discarded.
  - From IDLE, REQ_OP or REQ_ARG, the FSM goes to IDLE. No rd_start is issued that cycle.
  - From WAIT_OP or WAIT_ARG without rd_done, the FSM goes to DRAIN.
  - From WAIT_OP or WAIT_ARG with rd_done in the same cycle, the byte is discarded and the FSM goes to IDLE.
  - In DRAIN, a redirect only updates fetch_pc.
- Full: with fifo_count==DEPTH the FSM stays in IDLE. Fetch resumes on the cycle after a pop.
- Reset mid-read: all state clears. After reset, REQ_OP waits for rd_busy=0, so a read still finishing in the reader is never overlapped.

Test Plan:
- Reset release, reader returns opcode 0x03 then operand 0xA5 -> rd_addr 0x0000 then 0x0001; 1 cycle after the second rd_done: instr_valid=1, opcode=3, operand=0xA5, instr_pc=0; next fetch at rd_addr 0x0002.
- instr_ready held 0 -> exactly 4 instructions fetched (PCs 0-3), fifo_count=4, no rd_start afterwards; one pop -> fetch of PC 4 (rd_addr 0x0008) starts within 2 cycles.
- redirect with redirect_pc=0x010 while in WAIT_OP -> FSM in DRAIN, the pending byte is discarded, next rd_addr=0x0020, FIFO empty, and instr_pc of the next instruction is 0x010.
- fetch_pc=0xFFF -> fetches at rd_addr 0x1FFE/0x1FFF, then the next rd_addr is 0x0000 and the pushed instr_pc is 0xFFF then 0x000.
- rd_busy held high 10 cycles in REQ_OP -> no rd_start during busy; one pulse on the cycle busy falls.
- Simultaneous push and pop with count=2 -> count stays 2 and the head order is preserved; simultaneous redirect and pop -> count=0 next cycle.
